uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo_mem.sv | 32 +++
 rtl/uart_rx_fifo.sv | 98 +++++++++
 tb/tb_uart_rx_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and width helper for the UART receive path.
// Revision: 1.0
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W_DEF   = 8;
  localparam int RX_FIFO_DEPTH_DEF = 16;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read, unreset.
// Revision: 1.0
`default_nettype none

module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W_DEF,
  parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO with count/flag decode.
// Revision: 1.0 -- sticky overrun flag enabled by macro UART_RX_FIFO_OVERRUN_EN.
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W_DEF,
  parameter int DEPTH     = RX_FIFO_DEPTH_DEF,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          set_flag,
  input  logic [DATA_W-1:0]             data,
  input  logic                          clear_flag,
  input  logic                          ovr_clr,
  output logic [DATA_W-1:0]             out_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic                          rx_afull,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              drop;

  // Flags decode from the count register only, so no input reaches an output.
  assign rx_empty = (count == '0);
  assign rx_full  = (count == FULL_LVL);
  assign rx_afull = (count >= AFULL_C);

  // A pop frees a slot in the same edge, so a push while full is still accepted.
  assign pop  = clear_flag && !rx_empty;
  assign push = set_flag && (!rx_full || pop);
  assign drop = set_flag && !push;

  assign out_data = rx_empty ? '0 : head;

  uart_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  // A drop in the same cycle as ovr_clr keeps the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = ovr_clr ^ drop;
  assign overrun    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo (DATA_W=8, DEPTH=16).
// Revision: 1.0
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       set_flag;
  logic [7:0] data;
  logic       clear_flag;
  logic       ovr_clr;
  logic [7:0] out_data;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_afull;
  logic [4:0] count;
  logic       overrun;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] q[$];
  bit m_ovr = 1'b0;

  uart_rx_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .set_flag   (set_flag),
    .data       (data),
    .clear_flag (clear_flag),
    .ovr_clr    (ovr_clr),
    .out_data   (out_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_afull   (rx_afull),
    .count      (count),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string where);
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    chk({where, ":out_data"}, 32'(out_data), 32'(head));
    chk({where, ":count"},    32'(count),    32'(q.size()));
    chk({where, ":empty"},    32'(rx_empty), 32'(q.size() == 0));
    chk({where, ":full"},     32'(rx_full),  32'(q.size() == DEPTH));
    chk({where, ":afull"},    32'(rx_afull), 32'(q.size() >= DEPTH - 2));
    chk({where, ":overrun"},  32'(overrun),  32'(m_ovr));
  endtask

  // Drive one cycle from a negedge, update the model, and check at the next negedge.
  task automatic step(input string where, input bit p, input logic [7:0] d,
                      input bit c, input bit oc);
    bit pe;
    bit we;
    logic [7:0] exp_pop;
    set_flag = p; data = d; clear_flag = c; ovr_clr = oc;
    pe = c && (q.size() > 0);
    we = p && ((q.size() < DEPTH) || pe);
    if (pe) begin
      exp_pop = q.pop_front();
      chk({where, ":pop_data"}, 32'(out_data), 32'(exp_pop));
    end
    if (we) q.push_back(d);
    if (OVR_EN) begin
      if (p && !we) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    set_flag = 1'b0; clear_flag = 1'b0; ovr_clr = 1'b0;
    check_state(where);
  endtask

  initial begin
    reset = 1'b0; set_flag = 1'b0; data = '0; clear_flag = 1'b0; ovr_clr = 1'b0;
    #5;
    check_state("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_state("post_reset");

    // single word through and out
    step("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("pop_a5",  1'b0, 8'h00, 1'b1, 1'b0);

    // fill, then overflow
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf_ff", 1'b1, 8'hFF, 1'b0, 1'b0);
    step("ovf_set_wins", 1'b1, 8'hFE, 1'b0, 1'b1);
    step("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // push and pop together while full
    step("full_pp", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // push and pop together while empty, then pop on empty
    step("empty_pp", 1'b1, 8'h3C, 1'b1, 1'b0);
    step("pop_3c", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    // pointer wrap with steady occupancy
    for (int i = 0; i < 5; i++) step("preload", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("wrap_pp", 1'b1, 8'($urandom), 1'b1, 1'b0);
    step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    #3;
    reset = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    #1;
    check_state("async_reset");
    @(negedge clock);
    reset = 1'b1;
    step("first_after_reset", 1'b1, 8'h11, 1'b0, 1'b0);
    step("pop_11", 1'b0, 8'h00, 1'b1, 1'b0);

    // overflow by three, stored data stays intact
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("ovf3", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
